packed_bus_serializer: RTL
==========================

# packed_bus_serializer

- Streams a flat packed bus of `LEN` elements of `WIDTH` bits out one element per handshake; element `i` occupies bits `[WIDTH*i +: WIDTH]`.
- A per-element enable mask selects which elements are emitted, so only active ring-oscillator counter slots leave the measurement fabric.
- The block is the consuming end of packed port-array buses: it sits between the packed result bus of the RO measurement array and the narrow result stream into the readout FIFO/AXI bridge.

## Interface
- `WIDTH`, 32, element width in bits (≥1)
- `LEN`, 8, number of elements in the packed bus (≥1)
- `IDX_W`, `$clog2(LEN)` (minimum 1), width of the element index output
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  reset; asynchronous, active-high
- `s_data`  in  WIDTH*LEN  packed input word
- `s_mask`  in  LEN  element enable; bit `i` enables element `i`
- `s_valid`  in  1  input word valid
- `s_ready`  out  1  block can accept a word
- `m_data`  out  WIDTH  current element
- `m_idx`  out  IDX_W  index of current element
- `m_last`  out  1  current element is the last enabled one of the word
- `m_valid`  out  1  output element valid
- `m_ready`  in  1  downstream accepts element
- `busy`  out  1  a word is held and not yet fully emitted

## Operation
- States are `IDLE` and `SEND`.
- `IDLE`: `s_ready=1`. A word is accepted on `s_valid && s_ready`.
  - If the mask is non-zero: latch `s_data` into the shadow register, latch `s_mask` into the remaining-mask register, and go to `SEND`.
  - If the mask is all-zero: drop the word, stay in `IDLE`, and hold `s_ready=1`. No output is produced.
- `SEND`: `s_ready=0`, `busy=1`, `m_valid=1`.
  - `m_data`/`m_idx` present the lowest set bit of the remaining mask.
  - `m_last=1` when the remaining mask has exactly one bit set.
- On `m_valid && m_ready`, clear the current bit in the remaining mask.
  - If that element was last, go to `IDLE`.
  - Otherwise present the next lowest set bit in the following cycle.
- Elements are emitted in ascending index order. Disabled elements are skipped with no bubble cycles.
- AXI-stream rule: while `m_valid && !m_ready`, `m_data`, `m_idx` and `m_last` are held stable.
- `s_data`/`s_mask` changes while in `SEND` have no effect.
- `m_data`, `m_idx` and `m_last` are registered outputs; there is no combinational path from `s_*` to `m_*`.

## Timing
- Reset (asynchronous assert, synchronous release): `s_ready=0`, `m_valid=0`, `m_last=0`, `busy=0`, `m_data=0`, `m_idx=0`, state `IDLE`.
- `s_ready` goes to 1 on the first rising edge after `rst` deasserts.
- Input handshake at edge T → `m_valid=1` with the first enabled element after edge T+1. First-element latency is 1 cycle.
- With `m_ready` held high, a word with K enabled elements occupies K consecutive cycles of `m_valid`.
- Last output handshake at edge U → state `IDLE` and `s_ready=1` after edge U+1.
  - There is one bubble between words.
  - Sustained throughput is K elements per K+1 cycles.
- Reset asserted mid-`SEND` immediately clears `m_valid` and discards the remaining elements. There is no partial replay after release.
- `LEN=1`: every emitted element has `m_last=1` and `m_idx=0`.

## Structure
- Shared header `stream_defs.vh`, guarded against double inclusion, holds:
  - the state encoding localparams `ST_IDLE=1'b0`, `ST_SEND=1'b1`;
  - a `clog2_min1` constant function reused by other packed-bus blocks.
- Sub-module `lsb_prienc`, parameter `N`:
  - combinational lowest-set-bit priority encoder;
  - outputs the index, `found`, and `single` (popcount==1);
  - one instance drives next-index selection and `m_last`.
- Element mux is a variable part-select on the shadow register: `[WIDTH*idx +: WIDTH]`.

## Test plan
- `WIDTH=8`, `LEN=4`, `s_data=32'h44332211`, `s_mask=4'b1111`, `m_ready=1` → `m_data` 11,22,33,44 on consecutive cycles; `m_idx` 0..3; `m_last` only with 44; `s_ready` returns 1 cycle after 44.
- Same data, `s_mask=4'b1010` → exactly two elements, 22 (idx 1) then 44 (idx 3, `m_last=1`), no gap between them.
- `s_mask=4'b0000`, `s_valid` held 3 cycles → 3 words accepted, `m_valid` never asserts, `s_ready` stays 1.
- `s_mask=4'b1111`, `m_ready` toggled 0/1 each cycle, `s_data` changed during `SEND` → `m_data`/`m_idx` stable while stalled; output still 11,22,33,44 from the latched word.
- `rst` asserted after the second element is accepted → `m_valid`, `busy`, `s_ready` drop asynchronously; after release a new word `32'hDDCCBBAA`, mask `1111` emits AA..DD with `m_idx` from 0.
- Back-to-back words with `s_valid` held high and masks `0001` then `1000` → 11 (idx 0, last), one bubble cycle, then 44 (idx 3, last).

Source files
------------

// File: rtl/packed_bus_serializer_pkg.sv
// Shared state encoding and sizing helper for the packed-bus stream blocks.
package packed_bus_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Index width that never collapses to zero bits for single-element buses.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lsb_prienc.sv
// Lowest-set-bit priority encoder with any-set and exactly-one-set flags.
// Purely combinational, zero latency; no flow control.
module lsb_prienc
  import packed_bus_serializer_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic          single
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign found  = |vec;
  assign single = found && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/packed_bus_serializer.sv
// Emits the enabled elements of a packed word one per handshake, lowest index first.
// First element 1 cycle after accept; m_* held while m_ready is low; one idle cycle between words.
module packed_bus_serializer
  import packed_bus_serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = 8,
  parameter int IDX_W = clog2_min1(LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH*LEN-1:0] s_data,
  input  logic [LEN-1:0]       s_mask,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [IDX_W-1:0]     m_idx,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic                 ready_q;
  logic [WIDTH*LEN-1:0] shadow_q;
  logic [LEN-1:0]       rem_q;

  logic                 load;
  logic                 adv;
  logic [LEN-1:0]       cur_bit;
  logic [LEN-1:0]       rem_clr;
  logic [LEN-1:0]       scan_mask;
  logic [WIDTH*LEN-1:0] scan_data;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 nxt_found;
  logic                 nxt_single;
  logic [WIDTH-1:0]     sel_data;

  assign s_ready = ready_q && (state_q == ST_IDLE);
  assign m_valid = (state_q == ST_SEND);
  assign busy    = (state_q == ST_SEND);

  // All-zero masks are accepted but never leave IDLE.
  assign load = (state_q == ST_IDLE) && s_valid && s_ready && (|s_mask);
  assign adv  = (state_q == ST_SEND) && m_ready;

  assign cur_bit = LEN'(1) << m_idx;
  assign rem_clr = rem_q & ~cur_bit;

  // One encoder looks ahead at whichever mask the registers will hold next.
  assign scan_mask = load ? s_mask : rem_clr;
  assign scan_data = load ? s_data : shadow_q;

  lsb_prienc #(
    .N  (LEN),
    .IW (IDX_W)
  ) u_prienc (
    .vec    (scan_mask),
    .idx    (nxt_idx),
    .found  (nxt_found),
    .single (nxt_single)
  );

  assign sel_data = scan_data[WIDTH*nxt_idx +: WIDTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_SEND;
      ST_SEND: if (adv && !nxt_found) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      shadow_q <= '0;
      rem_q    <= '0;
      m_data   <= '0;
      m_idx    <= '0;
      m_last   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (load) begin
        shadow_q <= s_data;
        rem_q    <= s_mask;
      end else if (adv) begin
        rem_q <= rem_clr;
      end
      if (load || (adv && nxt_found)) begin
        m_data <= sel_data;
        m_idx  <= nxt_idx;
        m_last <= nxt_single;
      end else if (adv) begin
        m_last <= 1'b0;
      end
    end
  end

endmodule
